ste_lmc1992: RTL and testbench
==============================

STE_LMC1992 -- requirements
Module: ste_lmc1992

Interface
REQ-001 SHALL provide parameter ADDR_CODE, default 2'b10, the LMC1992 device address matched in command bits [10:9].
REQ-002 clk  in  1  system clock, 32 MHz.
REQ-003 reset  in  1  reset: synchronous, active-high, sampled on clk.
REQ-004 mw_bit_en  in  1  one-clk pulse per Microwire bit slot, aligned to a clk_8_en cycle.
REQ-005 mw_clk  in  1  mask bit for the current slot; 1 = mw_data valid.
REQ-006 mw_data  in  1  serial Microwire data, MSB first.
REQ-007 mw_done  in  1  one-clk pulse marking end of a 16-slot transfer.
REQ-008 audio_strobe  in  1  one-clk sample-rate pulse.
REQ-009 audio_in_l / audio_in_r  in  8 each  offset-binary samples.
REQ-010 audio_out_l / audio_out_r  out  8 each  attenuated offset-binary samples.
REQ-011 out_strobe  out  1  one-clk pulse when both outputs update.
REQ-012 overrun  out  1  one-clk pulse when audio_strobe is dropped.
REQ-013 master_vol 6, left_vol 5, right_vol 5, bass 4, treble 4, mix 2  out  current register values.
REQ-014 cmd_valid / cmd_err  out  1 each  one-clk pulses: command accepted / command rejected.

Function
REQ-015 Receiver SHALL shift mw_data into an 11-bit register (new bit at LSB) on each clk where mw_bit_en=1 and mw_clk=1, and SHALL count the accepted bits with saturation at 12.
REQ-016 A clk with mw_done=1 SHALL evaluate the command, SHALL clear the bit counter, and SHALL ignore any mw_bit_en in the same clk.
REQ-017 A command SHALL be valid only when the bit count is exactly 11, bits [10:9]=ADDR_CODE and reg=bits[8:6] is not 3'b110 or 3'b111; otherwise cmd_err SHALL pulse and no register SHALL change.
REQ-018 Register decode: 000 mix<=d[1:0]; 001 bass<=d[3:0]; 010 treble<=d[3:0]; 011 master_vol<=d[5:0]; 100 right_vol<=d[4:0]; 101 left_vol<=d[4:0], where d=bits[5:0].
REQ-019 A register update and cmd_valid SHALL occur one clk after mw_done.
REQ-020 Values above range (master>40, side>20) SHALL be stored unchanged and SHALL be clamped only in the gain computation.
REQ-021 Attenuation per channel: att = (40-min(master,40)) + (20-min(side,20)), range 0..60, in units of 2 dB.
REQ-022 Gain: shift=att/3, frac=att%3, multiplier g = 256/203/161 for frac 0/1/2.
REQ-023 Datapath: s = input with MSB inverted, treated as signed 8-bit; r = (s*g) >>> 8, then >>> shift (both arithmetic); result SHALL be forced to 0 when shift>=8; output = r[7:0] with MSB inverted.
REQ-024 A single shared multiplier SHALL be used, sequenced by the FSM IDLE -> LEFT -> RIGHT -> IDLE.
REQ-025 In IDLE, audio_strobe SHALL latch both inputs and both channel attenuations, then move to LEFT.
REQ-026 LEFT SHALL compute the left result; RIGHT SHALL compute the right result; on leaving RIGHT, both outputs SHALL update together and out_strobe SHALL pulse.
REQ-027 Latency: strobe at clk N -> outputs and out_strobe valid at clk N+3.
REQ-028 audio_strobe in LEFT or RIGHT SHALL be dropped and SHALL pulse overrun in that clk.
REQ-029 Register writes during LEFT or RIGHT SHALL NOT affect the sample in flight.
REQ-030 mix, bass and treble SHALL be exported only; they SHALL NOT alter the datapath.

Reset
REQ-031 reset SHALL set master_vol=40, left_vol=20, right_vol=20, bass=6, treble=6, mix=2'b01, audio_out_l/r=8'h80, FSM=IDLE, bit counter=0, and all pulse outputs=0.
REQ-032 reset mid-transfer or mid-sample SHALL discard the partial command or sample with no pulse emitted.

Verification
REQ-033 Shift 11 bits 0x4E8 (master=40) then mw_done -> cmd_valid at the next clk, master_vol=40; then strobe with in_l=8'hC0 -> out_l=8'hC0 at N+3.
REQ-034 Command master=34 (att 6, shift 2, g 256), in_l=8'hC0 (s=+64) -> out_l=8'h90.
REQ-035 Command left_vol=19 (att 1, g 203), in_l=8'h00 (s=-128) -> out_l=8'h1A (r=-102); right channel unchanged.
REQ-036 Transfer of 10 bits, or 11 bits with reg=3'b111 or address 2'b01 -> cmd_err pulse, all registers unchanged.
REQ-037 audio_strobe at N and N+1 -> overrun at N+1, single out_strobe at N+3.
REQ-038 master_vol=0 -> every output = 8'h80; assert reset during RIGHT -> no out_strobe, defaults restored.

Source files
------------

// File: rtl/ste_lmc1992_if.sv
// Microwire command bus into the LMC1992 volume/tone controller model.
// Signals: mw_bit_en (bit-slot pulse), mw_clk (slot mask, 1 = data valid),
//          mw_data (serial data, MSB first), mw_done (end-of-transfer pulse).
// Modports: master drives the bus, slave (the controller) receives it.
interface ste_lmc1992_if;
    logic mw_bit_en;
    logic mw_clk;
    logic mw_data;
    logic mw_done;

    modport master (
        output mw_bit_en,
        output mw_clk,
        output mw_data,
        output mw_done
    );

    modport slave (
        input mw_bit_en,
        input mw_clk,
        input mw_data,
        input mw_done
    );
endinterface

// File: rtl/ste_lmc1992.sv
// LMC1992 controller: Microwire command receiver, register file and a
// stereo attenuator that time-shares one multiplier over both channels.
// Ports: clk, reset (sync, active-high); mw (Microwire bus, slave);
//   audio_strobe, audio_in_l/r -> audio_out_l/r, out_strobe, overrun;
//   master_vol, left_vol, right_vol, bass, treble, mix (register values);
//   cmd_valid / cmd_err (per-command accept / reject pulses).
module ste_lmc1992 #(
    parameter logic [1:0] ADDR_CODE = 2'b10
) (
    input  logic        clk,
    input  logic        reset,
    ste_lmc1992_if.slave mw,
    input  logic        audio_strobe,
    input  logic [7:0]  audio_in_l,
    input  logic [7:0]  audio_in_r,
    output logic [7:0]  audio_out_l,
    output logic [7:0]  audio_out_r,
    output logic        out_strobe,
    output logic        overrun,
    output logic [5:0]  master_vol,
    output logic [4:0]  left_vol,
    output logic [4:0]  right_vol,
    output logic [3:0]  bass,
    output logic [3:0]  treble,
    output logic [1:0]  mix,
    output logic        cmd_valid,
    output logic        cmd_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    // ---------------- Microwire receiver ----------------
    logic [10:0] sreg;
    logic [3:0]  bcnt;
    logic        cmd_ok;

    // Register codes 110 and 111 do not exist.
    assign cmd_ok = (bcnt == 4'd11)
                 && (sreg[10:9] == ADDR_CODE)
                 && (sreg[8:7] != 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg       <= '0;
            bcnt       <= '0;
            cmd_valid  <= 1'b0;
            cmd_err    <= 1'b0;
            master_vol <= 6'd40;
            left_vol   <= 5'd20;
            right_vol  <= 5'd20;
            bass       <= 4'd6;
            treble     <= 4'd6;
            mix        <= 2'b01;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            if (mw.mw_done) begin
                // End of transfer wins over any bit slot in the same clock.
                bcnt      <= '0;
                cmd_valid <= cmd_ok;
                cmd_err   <= !cmd_ok;
                if (cmd_ok) begin
                    unique case (sreg[8:6])
                        3'b000:  mix        <= sreg[1:0];
                        3'b001:  bass       <= sreg[3:0];
                        3'b010:  treble     <= sreg[3:0];
                        3'b011:  master_vol <= sreg[5:0];
                        3'b100:  right_vol  <= sreg[4:0];
                        3'b101:  left_vol   <= sreg[4:0];
                        default: ;
                    endcase
                end
            end else if (mw.mw_bit_en && mw.mw_clk) begin
                sreg <= {sreg[9:0], mw.mw_data};
                // Saturate at 12 so over-long transfers never look like 11.
                if (bcnt != 4'd12) begin
                    bcnt <= bcnt + 4'd1;
                end
            end
        end
    end

    // ---------------- Attenuation ----------------
    // Out-of-range settings are clamped here only; stored values are kept.
    function automatic logic [5:0] att_of(
        input logic [5:0] m,
        input logic [4:0] side
    );
        logic [5:0] m_c;
        logic [4:0] s_c;
        m_c = (m > 6'd40) ? 6'd40 : m;
        s_c = (side > 5'd20) ? 5'd20 : side;
        return 6'd60 - m_c - {1'b0, s_c};
    endfunction

    // ---------------- Sequencer ----------------
    state_t     state;
    state_t     state_nxt;
    logic [7:0] in_l_q;
    logic [7:0] in_r_q;
    logic [5:0] att_l_q;
    logic [5:0] att_r_q;
    logic [7:0] res_l_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (audio_strobe) state_nxt = LEFT;
            LEFT:    state_nxt = RIGHT;
            RIGHT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A strobe while a sample is in flight is dropped and flagged at once.
    assign overrun = audio_strobe && (state != IDLE) && !reset;

    // ---------------- Shared multiplier ----------------
    logic [7:0]         sel_in;
    logic [5:0]         sel_att;
    logic [4:0]         shift;
    logic [5:0]         frac;
    logic signed [7:0]  s;
    logic signed [9:0]  gs;
    logic signed [15:0] prod;
    logic [7:0]         shr;
    logic [7:0]         res;

    assign sel_in  = (state == RIGHT) ? in_r_q : in_l_q;
    assign sel_att = (state == RIGHT) ? att_r_q : att_l_q;
    assign shift   = 5'(sel_att / 6'd3);
    assign frac    = sel_att % 6'd3;

    // Gain steps of 2 dB inside each 6 dB octave: 256, 203, 161 (/256).
    always_comb begin
        gs = 10'sd256;
        unique case (frac)
            6'd1:    gs = 10'sd203;
            6'd2:    gs = 10'sd161;
            default: gs = 10'sd256;
        endcase
    end

    // Offset binary -> two's complement by flipping the MSB.
    assign s    = $signed({~sel_in[7], sel_in[6:0]});
    assign prod = s * gs;
    // (p >>> 8) >>> shift collapses to a single arithmetic shift.
    assign shr  = 8'(prod >>> (5'd8 + shift));
    assign res  = (shift >= 5'd8) ? 8'h00 : shr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_l_q      <= 8'h80;
            in_r_q      <= 8'h80;
            att_l_q     <= '0;
            att_r_q     <= '0;
            res_l_q     <= '0;
            audio_out_l <= 8'h80;
            audio_out_r <= 8'h80;
            out_strobe  <= 1'b0;
        end else begin
            state      <= state_nxt;
            out_strobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Snapshot gains so later writes can't touch this sample.
                    if (audio_strobe) begin
                        in_l_q  <= audio_in_l;
                        in_r_q  <= audio_in_r;
                        att_l_q <= att_of(master_vol, left_vol);
                        att_r_q <= att_of(master_vol, right_vol);
                    end
                end
                LEFT: begin
                    res_l_q <= res;
                end
                RIGHT: begin
                    audio_out_l <= {~res_l_q[7], res_l_q[6:0]};
                    audio_out_r <= {~res[7], res[6:0]};
                    out_strobe  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ste_lmc1992.sv
// Randomised self-checking bench for ste_lmc1992 against an arithmetic
// model of the LMC1992 register file and attenuation law.
module tb_ste_lmc1992;

    logic       clk = 1'b0;
    logic       reset;
    logic       audio_strobe;
    logic [7:0] audio_in_l;
    logic [7:0] audio_in_r;
    logic [7:0] audio_out_l;
    logic [7:0] audio_out_r;
    logic       out_strobe;
    logic       overrun;
    logic [5:0] master_vol;
    logic [4:0] left_vol;
    logic [4:0] right_vol;
    logic [3:0] bass;
    logic [3:0] treble;
    logic [1:0] mix;
    logic       cmd_valid;
    logic       cmd_err;

    ste_lmc1992_if mw_bus ();

    ste_lmc1992 dut (
        .clk          (clk),
        .reset        (reset),
        .mw           (mw_bus.slave),
        .audio_strobe (audio_strobe),
        .audio_in_l   (audio_in_l),
        .audio_in_r   (audio_in_r),
        .audio_out_l  (audio_out_l),
        .audio_out_r  (audio_out_r),
        .out_strobe   (out_strobe),
        .overrun      (overrun),
        .master_vol   (master_vol),
        .left_vol     (left_vol),
        .right_vol    (right_vol),
        .bass         (bass),
        .treble       (treble),
        .mix          (mix),
        .cmd_valid    (cmd_valid),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference register file
    int m_master, m_left, m_right, m_bass, m_treble, m_mix;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_master = 40; m_left = 20; m_right = 20;
        m_bass = 6; m_treble = 6; m_mix = 1;
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Output = input attenuated by att*2 dB, rounded toward -inf.
    function automatic int exp_out(input int in, input int master, input int side);
        int mc, sc, att, sh, g, v;
        int gt[3] = '{256, 203, 161};
        mc  = (master > 40) ? 40 : master;
        sc  = (side > 20) ? 20 : side;
        att = (40 - mc) + (20 - sc);
        sh  = att / 3;
        g   = gt[att % 3];
        if (sh >= 8) return 128;
        v = fdiv((in - 128) * g, 256);
        v = fdiv(v, 1 << sh);
        return (v + 128) & 255;
    endfunction

    function automatic bit cmd_good(input logic [10:0] w, input int nb);
        return (nb == 11) && (w[10:9] == 2'b10) && (w[8:7] != 2'b11);
    endfunction

    task automatic model_write(input logic [10:0] w);
        int d;
        d = int'(w[5:0]);
        case (w[8:6])
            3'd0: m_mix    = d & 3;
            3'd1: m_bass   = d & 15;
            3'd2: m_treble = d & 15;
            3'd3: m_master = d;
            3'd4: m_right  = d & 31;
            3'd5: m_left   = d & 31;
            default: ;
        endcase
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".master"}, 32'(master_vol), 32'(m_master));
        chk({tag, ".left"},   32'(left_vol),   32'(m_left));
        chk({tag, ".right"},  32'(right_vol),  32'(m_right));
        chk({tag, ".bass"},   32'(bass),       32'(m_bass));
        chk({tag, ".treble"}, 32'(treble),     32'(m_treble));
        chk({tag, ".mix"},    32'(mix),        32'(m_mix));
    endtask

    // Shift nb bits of w (MSB first) with random gaps and masked slots.
    task automatic shift_bits(input logic [15:0] w, input int nb);
        for (int i = nb - 1; i >= 0; i--) begin
            repeat ($urandom_range(0, 2)) begin
                mw_bus.mw_bit_en = 1'b0;
                tick();
            end
            if ($urandom_range(0, 3) == 0) begin
                mw_bus.mw_bit_en = 1'b1;
                mw_bus.mw_clk    = 1'b0;
                mw_bus.mw_data   = 1'($urandom);
                tick();
            end
            mw_bus.mw_bit_en = 1'b1;
            mw_bus.mw_clk    = 1'b1;
            mw_bus.mw_data   = w[i];
            tick();
        end
        mw_bus.mw_bit_en = 1'b0;
        mw_bus.mw_clk    = 1'b0;
    endtask

    // mw_done pulse (sometimes with a live bit slot that must be ignored).
    task automatic send_cmd(input string tag, input logic [15:0] w, input int nb);
        bit good;
        shift_bits(w, nb);
        good = cmd_good(w[10:0], nb);
        mw_bus.mw_done = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            mw_bus.mw_bit_en = 1'b1;
            mw_bus.mw_clk    = 1'b1;
            mw_bus.mw_data   = 1'($urandom);
        end
        tick();
        mw_bus.mw_done   = 1'b0;
        mw_bus.mw_bit_en = 1'b0;
        mw_bus.mw_clk    = 1'b0;
        chk({tag, ".valid"}, 32'(cmd_valid), 32'(good));
        chk({tag, ".err"},   32'(cmd_err),   32'(!good));
        if (good) model_write(w[10:0]);
        check_regs(tag);
    endtask

    task automatic run_sample(input string tag, input logic [7:0] l,
                              input logic [7:0] r);
        int el, er;
        el = exp_out(int'(l), m_master, m_left);
        er = exp_out(int'(r), m_master, m_right);
        audio_strobe = 1'b1;
        audio_in_l   = l;
        audio_in_r   = r;
        #1;
        chk({tag, ".ovr_idle"}, 32'(overrun), 32'd0);
        tick();
        audio_strobe = 1'b0;
        audio_in_l   = 8'($urandom);
        audio_in_r   = 8'($urandom);
        chk({tag, ".ostb_n1"}, 32'(out_strobe), 32'd0);
        tick();
        chk({tag, ".ostb_n2"}, 32'(out_strobe), 32'd0);
        tick();
        chk({tag, ".ostb_n3"}, 32'(out_strobe), 32'd1);
        chk({tag, ".out_l"},   32'(audio_out_l), 32'(el));
        chk({tag, ".out_r"},   32'(audio_out_r), 32'(er));
    endtask

    function automatic logic [15:0] mk(input int rg, input int d);
        logic [15:0] w;
        w = 16'({2'b10, 3'(rg), 6'(d)});
        return w;
    endfunction

    initial begin
        int el, er, ostb;
        logic [10:0] bad;
        reset            = 1'b1;
        audio_strobe     = 1'b0;
        audio_in_l       = 8'h00;
        audio_in_r       = 8'h00;
        mw_bus.mw_bit_en = 1'b0;
        mw_bus.mw_clk    = 1'b0;
        mw_bus.mw_data   = 1'b0;
        mw_bus.mw_done   = 1'b0;
        model_reset();
        repeat (3) tick();
        check_regs("rst");
        chk("rst.out_l", 32'(audio_out_l), 32'h80);
        chk("rst.out_r", 32'(audio_out_r), 32'h80);
        chk("rst.ostb",  32'(out_strobe), 32'd0);
        chk("rst.cval",  32'(cmd_valid), 32'd0);
        chk("rst.cerr",  32'(cmd_err), 32'd0);
        reset = 1'b0;
        tick();

        // Directed cases
        send_cmd("m40", 16'h04E8, 11);
        run_sample("m40s", 8'hC0, 8'h40);
        chk("m40.abs", 32'(audio_out_l), 32'hC0);
        send_cmd("m34", mk(3, 34), 11);
        run_sample("m34s", 8'hC0, 8'h33);
        chk("m34.abs", 32'(audio_out_l), 32'h90);
        send_cmd("m40b", mk(3, 40), 11);
        send_cmd("l19", mk(5, 19), 11);
        run_sample("l19s", 8'h00, 8'h00);
        chk("l19.abs", 32'(audio_out_l), 32'h1A);
        chk("l19.r",   32'(audio_out_r), 32'h00);

        // Rejected transfers
        send_cmd("b10", mk(3, 5), 10);
        send_cmd("b12", mk(3, 5), 12);
        bad = 11'b10_111_000101;
        send_cmd("breg", 16'(bad), 11);
        bad = 11'b10_110_000101;
        send_cmd("breg6", 16'(bad), 11);
        bad = 11'b01_011_000101;
        send_cmd("badr", 16'(bad), 11);

        // Over-range values stored, clamped only in the gain
        send_cmd("m63", mk(3, 63), 11);
        send_cmd("r31", mk(4, 31), 11);
        run_sample("ovr_rng", 8'($urandom), 8'($urandom));

        // Back-to-back strobes
        el = exp_out(8'hF0, m_master, m_left);
        er = exp_out(8'h11, m_master, m_right);
        audio_strobe = 1'b1; audio_in_l = 8'hF0; audio_in_r = 8'h11;
        tick();
        audio_in_l = 8'h01; audio_in_r = 8'hFE;
        #1;
        chk("b2b.ovr", 32'(overrun), 32'd1);
        tick();
        audio_strobe = 1'b0;
        tick();
        chk("b2b.ostb", 32'(out_strobe), 32'd1);
        chk("b2b.l", 32'(audio_out_l), 32'(el));
        chk("b2b.r", 32'(audio_out_r), 32'(er));
        ostb = 0;
        repeat (4) begin
            tick();
            ostb += int'(out_strobe);
        end
        chk("b2b.extra", 32'(ostb), 32'd0);

        // Register write lands while a sample is in flight
        send_cmd("m38", mk(3, 38), 11);
        el = exp_out(8'hA5, m_master, m_left);
        er = exp_out(8'h5A, m_master, m_right);
        shift_bits(mk(3, 0), 11);
        audio_strobe = 1'b1; audio_in_l = 8'hA5; audio_in_r = 8'h5A;
        tick();
        audio_strobe = 1'b0;
        mw_bus.mw_done = 1'b1;
        tick();
        mw_bus.mw_done = 1'b0;
        chk("fly.cval", 32'(cmd_valid), 32'd1);
        model_write(11'(mk(3, 0)));
        tick();
        chk("fly.ostb", 32'(out_strobe), 32'd1);
        chk("fly.l", 32'(audio_out_l), 32'(el));
        chk("fly.r", 32'(audio_out_r), 32'(er));

        // master_vol = 0 mutes everything
        for (int i = 0; i < 4; i++) begin
            run_sample("mute", 8'($urandom), 8'($urandom));
            chk("mute.l", 32'(audio_out_l), 32'h80);
        end

        // Randomised commands and samples
        for (int i = 0; i < 30; i++) begin
            logic [15:0] w;
            int nb;
            w  = mk($urandom_range(0, 5), $urandom_range(0, 63));
            nb = 11;
            case ($urandom_range(0, 9))
                0: nb = $urandom_range(8, 13);
                1: w[10:9] = 2'($urandom);
                2: w[8:6] = 3'($urandom_range(6, 7));
                default: ;
            endcase
            if (w[8:6] == 3'd3 && $urandom_range(0, 1) == 1)
                w[5:0] = 6'($urandom_range(28, 44));
            send_cmd("rnd", w, nb);
            run_sample("rnds", 8'($urandom), 8'($urandom));
        end

        // Reset while RIGHT is active
        send_cmd("m36", mk(3, 36), 11);
        audio_strobe = 1'b1; audio_in_l = 8'hE0; audio_in_r = 8'h20;
        tick();
        audio_strobe = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        chk("rstR.ostb", 32'(out_strobe), 32'd0);
        chk("rstR.l", 32'(audio_out_l), 32'h80);
        chk("rstR.r", 32'(audio_out_r), 32'h80);
        check_regs("rstR");
        ostb = 0;
        repeat (4) begin
            tick();
            ostb += int'(out_strobe);
        end
        chk("rstR.late", 32'(ostb), 32'd0);

        // Reset mid-transfer discards partial bits
        shift_bits(16'h001F, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstT.cval", 32'(cmd_valid), 32'd0);
        chk("rstT.cerr", 32'(cmd_err), 32'd0);
        send_cmd("rstT", mk(4, 9), 11);
        run_sample("rstTs", 8'($urandom), 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
